purchase_ctrl: RTL and testbench
================================

// Module: purchase_ctrl
// PURPOSE
//   Inventory/payment writer for the vending machine: takes item selection, coin and confirm/cancel
//   pulses, tracks paid credit, dispenses, computes change and decrements per-item stock.
//   Drives left1..left4 consumed by the query/display path; sits beside it under the top level,
//   fed by debounced single-cycle button pulses.
// PARAMETERS
//   PRICE1        8'd4      price of item 1 (A)
//   PRICE2        8'd9      price of item 2 (B)
//   PRICE3        8'd13     price of item 3 (C)
//   PRICE4        8'd17     price of item 4 (D)
//   INIT_STOCK    8'd10     per-item stock after reset (and refill)
//   TIMEOUT       32'd500000000  clk cycles in PAY with no coin before automatic refund
// PORTS
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   payperiod  in   1  level: 1 = purchase session allowed
//   sel        in   4  one-hot item select pulse, bit0 = item 1 .. bit3 = item 4
//   coin1/coin5/coin10  in  1 each  single-cycle coin-inserted pulses (values 1/5/10)
//   confirm    in   1  pulse: request vend
//   cancel     in   1  pulse: abort session
//   refill     in   1  pulse: restock (only with REFILL_EN)
//   left1..left4 out 8 each  remaining stock per item
//   item       out  3  latched item 1..4, 0 = none
//   paid       out  8  credit inserted this session, 0..99
//   change     out  8  change/refund amount of last completed session
//   state      out  3  IDLE=0 SELECT=1 PAY=2 VEND=3 REFUND=4
//   done/refunded/sold_out/reject  out  1 each  single-cycle status pulses
// BEHAVIOUR
//   - Reset: state=IDLE, leftN=INIT_STOCK, item=0, paid=0, change=0, all pulses 0, timer=0.
//     Reset mid-session discards credit without refund pulse.
//   - IDLE: payperiod=1 -> SELECT (next cycle). All other inputs ignored.
//   - SELECT: sel one-hot bit k: stock>0 -> item=k+1, change=0, timer=0, -> PAY; stock=0 -> sold_out
//     pulse, stay. Non-one-hot sel ignored. cancel or payperiod=0 -> IDLE (no credit held).
//   - PAY, priority per cycle: payperiod=0 or cancel -> REFUND; else confirm: paid>=price(item) -> VEND,
//     paid<price -> reject pulse, stay; else coins.
//   - Coins: simultaneous pulses summed same cycle; if paid+sum>99 whole sum rejected (reject pulse,
//     paid unchanged); else paid+=sum, timer cleared. Coins in any state other than PAY ignored.
//     Coins arriving on a confirm/cancel cycle are dropped.
//   - Timer: counts each PAY cycle without accepted coin; at TIMEOUT-1 -> REFUND.
//   - VEND (one cycle): left[item]-=1, change=paid-price, done pulse, paid=0, item=0 -> IDLE.
//   - REFUND (one cycle): change=paid, refunded pulse, paid=0, item=0 -> IDLE.
//   - Stock never underflows (SELECT guards 0). change holds until next SELECT->PAY.
//   - All outputs registered; pulses high exactly one cycle in the cycle after the causing input.
// CONFIGURATION
//   PURCHASE_REFILL_EN defined: refill pulse in IDLE sets all leftN=INIT_STOCK next cycle; ignored
//     in other states.  Undefined: refill port present but ignored; stock only restored by rst.
// TESTING
//   - rst, payperiod=1, sel=0001, coin5 -> confirm: done, left1=9, change=1, state back to IDLE.
//   - Item 4: coin10 twice (paid=20), confirm -> done, change=3, left4=9; confirm at paid=10 -> reject.
//   - paid=95, coin5 -> paid=99? no: 100>99 -> reject, paid stays 95; coin1+coin5 same cycle at
//     paid=90 -> paid=96.
//   - PAY paid=6, cancel -> refunded, change=6, paid=0; repeat with payperiod dropped -> same result.
//   - Drain item 2 to 0 via 10 purchases, then sel=0010 -> sold_out, stay SELECT; with
//     PURCHASE_REFILL_EN refill in IDLE -> left2=10.
//   - TIMEOUT=16 build: enter PAY, coin1, idle 16 cycles -> refunded, change=1; rst in PAY -> IDLE, paid=0.

Source files
------------

// File: rtl/purchase_if.sv
// Handshake/status bundle between the vending-machine top level and purchase_ctrl.
// master drives buttons and coins; slave is the purchase controller.
interface purchase_if;
  logic       payperiod;
  logic [3:0] sel;
  logic       coin1;
  logic       coin5;
  logic       coin10;
  logic       confirm;
  logic       cancel;
  logic       refill;
  logic [7:0] left1;
  logic [7:0] left2;
  logic [7:0] left3;
  logic [7:0] left4;
  logic [2:0] item;
  logic [7:0] paid;
  logic [7:0] change;
  logic [2:0] state;
  logic       done;
  logic       refunded;
  logic       sold_out;
  logic       reject;

  modport master (
    output payperiod, sel, coin1, coin5, coin10, confirm, cancel, refill,
    input  left1, left2, left3, left4, item, paid, change, state,
    input  done, refunded, sold_out, reject
  );

  modport slave (
    input  payperiod, sel, coin1, coin5, coin10, confirm, cancel, refill,
    output left1, left2, left3, left4, item, paid, change, state,
    output done, refunded, sold_out, reject
  );
endinterface

// File: rtl/purchase_ctrl.sv
// Vending purchase controller: selection, coin credit, vend/refund, change and per-item stock.
// Optional PURCHASE_REFILL_EN: refill pulse in IDLE restores all stock to INIT_STOCK.
module purchase_ctrl #(
  parameter logic [7:0]  PRICE1     = 8'd4,
  parameter logic [7:0]  PRICE2     = 8'd9,
  parameter logic [7:0]  PRICE3     = 8'd13,
  parameter logic [7:0]  PRICE4     = 8'd17,
  parameter logic [7:0]  INIT_STOCK = 8'd10,
  parameter logic [31:0] TIMEOUT    = 32'd500000000
) (
  input logic        clk,
  input logic        rst,
  purchase_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSelect = 3'd1,
    StPay    = 3'd2,
    StVend   = 3'd3,
    StRefund = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      item_q, item_d;
  logic [7:0]      paid_q, paid_d;
  logic [7:0]      change_q, change_d;
  logic [3:0][7:0] left_q, left_d;
  logic [31:0]     timer_q, timer_d;
  logic            done_q, done_d;
  logic            refunded_q, refunded_d;
  logic            sold_out_q, sold_out_d;
  logic            reject_q, reject_d;

  logic [7:0] coin_sum;
  logic [7:0] paid_sum;
  logic       coin_any;
  logic       coin_fits;
  logic       coin_take;
  logic [7:0] price;
  logic [1:0] item_idx;
  logic       abort;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       sel_in_stock;
  logic       timeout_hit;
  logic       paid_enough;

  assign coin_sum     = {7'd0, bus.coin1} + (bus.coin5 ? 8'd5 : 8'd0)
                      + (bus.coin10 ? 8'd10 : 8'd0);
  assign paid_sum     = paid_q + coin_sum;
  assign coin_any     = |coin_sum;
  assign coin_fits    = paid_sum <= 8'd99;
  assign coin_take    = coin_any && coin_fits;
  assign abort        = !bus.payperiod || bus.cancel;
  assign item_idx     = 2'(item_q - 3'd1);
  assign sel_in_stock = left_q[sel_idx] != 8'd0;
  assign timeout_hit  = timer_q >= (TIMEOUT - 32'd1);
  assign paid_enough  = paid_q >= price;

`ifdef PURCHASE_REFILL_EN
  logic refill_req;
  assign refill_req = bus.refill;
`else
  logic unused_refill;
  assign unused_refill = bus.refill;
`endif

  always_comb begin
    unique case (item_idx)
      2'd0:    price = PRICE1;
      2'd1:    price = PRICE2;
      2'd2:    price = PRICE3;
      default: price = PRICE4;
    endcase
  end

  // Only a clean one-hot select names an item; anything else is ignored.
  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (bus.sel)
      4'b0001: sel_idx = 2'd0;
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      item_q     <= 3'd0;
      paid_q     <= 8'd0;
      change_q   <= 8'd0;
      left_q     <= {4{INIT_STOCK}};
      timer_q    <= 32'd0;
      done_q     <= 1'b0;
      refunded_q <= 1'b0;
      sold_out_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      paid_q     <= paid_d;
      change_q   <= change_d;
      left_q     <= left_d;
      timer_q    <= timer_d;
      done_q     <= done_d;
      refunded_q <= refunded_d;
      sold_out_q <= sold_out_d;
      reject_q   <= reject_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.payperiod) state_d = StSelect;
      end
      StSelect: begin
        if (abort)                          state_d = StIdle;
        else if (sel_valid && sel_in_stock) state_d = StPay;
      end
      StPay: begin
        if (abort) begin
          state_d = StRefund;
        end else if (bus.confirm) begin
          if (paid_enough) state_d = StVend;
        end else if (!coin_take && timeout_hit) begin
          state_d = StRefund;
        end
      end
      StVend:   state_d = StIdle;
      StRefund: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    item_d     = item_q;
    paid_d     = paid_q;
    change_d   = change_q;
    left_d     = left_q;
    timer_d    = timer_q;
    done_d     = 1'b0;
    refunded_d = 1'b0;
    sold_out_d = 1'b0;
    reject_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
`ifdef PURCHASE_REFILL_EN
        if (refill_req) left_d = {4{INIT_STOCK}};
`endif
      end
      StSelect: begin
        if (!abort && sel_valid) begin
          if (sel_in_stock) begin
            item_d   = {1'b0, sel_idx} + 3'd1;
            change_d = 8'd0;
            timer_d  = 32'd0;
          end else begin
            sold_out_d = 1'b1;
          end
        end
      end
      StPay: begin
        // Coins on a confirm/cancel cycle are dropped; rejected coins still age the timer.
        if (!abort) begin
          if (bus.confirm) begin
            if (!paid_enough) begin
              reject_d = 1'b1;
              timer_d  = timer_q + 32'd1;
            end
          end else if (coin_take) begin
            paid_d  = paid_sum;
            timer_d = 32'd0;
          end else begin
            reject_d = coin_any;
            timer_d  = timer_q + 32'd1;
          end
        end
      end
      StVend: begin
        left_d[item_idx] = left_q[item_idx] - 8'd1;
        change_d         = paid_q - price;
        done_d           = 1'b1;
        paid_d           = 8'd0;
        item_d           = 3'd0;
      end
      StRefund: begin
        change_d   = paid_q;
        refunded_d = 1'b1;
        paid_d     = 8'd0;
        item_d     = 3'd0;
      end
      default: ;
    endcase
  end

  assign bus.left1    = left_q[0];
  assign bus.left2    = left_q[1];
  assign bus.left3    = left_q[2];
  assign bus.left4    = left_q[3];
  assign bus.item     = item_q;
  assign bus.paid     = paid_q;
  assign bus.change   = change_q;
  assign bus.state    = state_q;
  assign bus.done     = done_q;
  assign bus.refunded = refunded_q;
  assign bus.sold_out = sold_out_q;
  assign bus.reject   = reject_q;

endmodule

// File: tb/tb_purchase_ctrl.sv
// Bench for purchase_ctrl: directed vector table, corner sequences, and random traffic
// compared every cycle against a session-level reference model (TIMEOUT shortened to 16).
module tb_purchase_ctrl;

  localparam int TimeoutCyc = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  purchase_if intf ();

  purchase_ctrl #(
    .TIMEOUT (32'(TimeoutCyc))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: session status kept as plain integers.
  int price_tab [4] = '{4, 9, 13, 17};
  int m_state, m_item, m_paid, m_change, m_timer;
  int m_left [4];
  bit m_done, m_ref, m_so, m_rej;

  typedef struct {
    bit          pp;
    logic [3:0]  sel;
    logic [2:0]  coins;   // {coin10, coin5, coin1}
    bit          conf;
    bit          canc;
    logic [2:0]  st;
    logic [2:0]  it;
    logic [7:0]  paid;
    logic [7:0]  chg;
    logic [31:0] left;    // {left4, left3, left2, left1}
    logic [3:0]  pul;     // {done, refunded, sold_out, reject}
  } vec_t;

  vec_t tbl [25];

  function automatic logic [63:0] act_vec();
    return {6'd0, intf.state, intf.item, intf.paid, intf.change,
            intf.left4, intf.left3, intf.left2, intf.left1,
            intf.done, intf.refunded, intf.sold_out, intf.reject};
  endfunction

  function automatic logic [63:0] mdl_vec();
    return {6'd0, 3'(m_state), 3'(m_item), 8'(m_paid), 8'(m_change),
            8'(m_left[3]), 8'(m_left[2]), 8'(m_left[1]), 8'(m_left[0]),
            m_done, m_ref, m_so, m_rej};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_step(input bit r, input bit pp, input logic [3:0] s,
                            input logic [2:0] coins, input bit conf, input bit canc,
                            input bit refl);
    int sum;
    sum = (coins[0] ? 1 : 0) + (coins[1] ? 5 : 0) + (coins[2] ? 10 : 0);
    m_done = 0; m_ref = 0; m_so = 0; m_rej = 0;
    if (r) begin
      m_state = 0; m_item = 0; m_paid = 0; m_change = 0; m_timer = 0;
      for (int i = 0; i < 4; i++) m_left[i] = 10;
      return;
    end
    case (m_state)
      0: begin
`ifdef PURCHASE_REFILL_EN
        if (refl) for (int i = 0; i < 4; i++) m_left[i] = 10;
`endif
        if (pp) m_state = 1;
      end
      1: begin
        if (!pp || canc) m_state = 0;
        else if ($countones(s) == 1) begin
          int k;
          k = 0;
          for (int i = 0; i < 4; i++) if (s[i]) k = i;
          if (m_left[k] > 0) begin
            m_item = k + 1; m_change = 0; m_timer = 0; m_state = 2;
          end else m_so = 1;
        end
      end
      2: begin
        if (!pp || canc) m_state = 4;
        else if (conf) begin
          if (m_paid >= price_tab[m_item-1]) m_state = 3;
          else begin m_rej = 1; m_timer++; end
        end else if (sum > 0 && m_paid + sum <= 99) begin
          m_paid += sum; m_timer = 0;
        end else begin
          if (sum > 0) m_rej = 1;
          if (m_timer >= TimeoutCyc - 1) m_state = 4;
          else m_timer++;
        end
      end
      3: begin
        m_left[m_item-1]--;
        m_change = m_paid - price_tab[m_item-1];
        m_done = 1; m_paid = 0; m_item = 0; m_state = 0;
      end
      default: begin
        m_change = m_paid; m_ref = 1; m_paid = 0; m_item = 0; m_state = 0;
      end
    endcase
  endtask

  task automatic step(input bit r, input bit pp, input logic [3:0] s, input logic [2:0] coins,
                      input bit conf, input bit canc, input bit refl);
    rst            = r;
    intf.payperiod = pp;
    intf.sel       = s;
    intf.coin1     = coins[0];
    intf.coin5     = coins[1];
    intf.coin10    = coins[2];
    intf.confirm   = conf;
    intf.cancel    = canc;
    intf.refill    = refl;
    @(posedge clk);
    model_step(r, pp, s, coins, conf, canc, refl);
    #1;
    check("model", act_vec(), mdl_vec());
  endtask

  task automatic idle_step();
    step(0, 1, 4'd0, 3'd0, 0, 0, 0);
  endtask

  task automatic go_pay(input int k);
    idle_step();
    step(0, 1, 4'(1 << k), 3'd0, 0, 0, 0);
  endtask

  localparam logic [31:0] L0 = {8'd10, 8'd10, 8'd10, 8'd10};
  localparam logic [31:0] L1 = {8'd10, 8'd10, 8'd10, 8'd9};
  localparam logic [31:0] L2 = {8'd9, 8'd10, 8'd10, 8'd9};

  initial begin
    tbl[0]  = '{1, 4'd0, 3'b000, 0, 0, 3'd1, 3'd0, 8'd0,  8'd0, L0, 4'b0000};
    tbl[1]  = '{1, 4'd1, 3'b000, 0, 0, 3'd2, 3'd1, 8'd0,  8'd0, L0, 4'b0000};
    tbl[2]  = '{1, 4'd0, 3'b010, 0, 0, 3'd2, 3'd1, 8'd5,  8'd0, L0, 4'b0000};
    tbl[3]  = '{1, 4'd0, 3'b000, 1, 0, 3'd3, 3'd1, 8'd5,  8'd0, L0, 4'b0000};
    tbl[4]  = '{1, 4'd0, 3'b000, 0, 0, 3'd0, 3'd0, 8'd0,  8'd1, L1, 4'b1000};
    tbl[5]  = '{1, 4'd0, 3'b000, 0, 0, 3'd1, 3'd0, 8'd0,  8'd1, L1, 4'b0000};
    tbl[6]  = '{1, 4'd8, 3'b000, 0, 0, 3'd2, 3'd4, 8'd0,  8'd0, L1, 4'b0000};
    tbl[7]  = '{1, 4'd0, 3'b100, 0, 0, 3'd2, 3'd4, 8'd10, 8'd0, L1, 4'b0000};
    tbl[8]  = '{1, 4'd0, 3'b000, 1, 0, 3'd2, 3'd4, 8'd10, 8'd0, L1, 4'b0001};
    tbl[9]  = '{1, 4'd0, 3'b100, 0, 0, 3'd2, 3'd4, 8'd20, 8'd0, L1, 4'b0000};
    tbl[10] = '{1, 4'd0, 3'b000, 1, 0, 3'd3, 3'd4, 8'd20, 8'd0, L1, 4'b0000};
    tbl[11] = '{1, 4'd0, 3'b000, 0, 0, 3'd0, 3'd0, 8'd0,  8'd3, L2, 4'b1000};
    tbl[12] = '{1, 4'd0, 3'b000, 0, 0, 3'd1, 3'd0, 8'd0,  8'd3, L2, 4'b0000};
    tbl[13] = '{1, 4'd2, 3'b000, 0, 0, 3'd2, 3'd2, 8'd0,  8'd0, L2, 4'b0000};
    tbl[14] = '{1, 4'd0, 3'b001, 0, 0, 3'd2, 3'd2, 8'd1,  8'd0, L2, 4'b0000};
    tbl[15] = '{1, 4'd0, 3'b010, 0, 0, 3'd2, 3'd2, 8'd6,  8'd0, L2, 4'b0000};
    tbl[16] = '{1, 4'd0, 3'b000, 0, 1, 3'd4, 3'd2, 8'd6,  8'd0, L2, 4'b0000};
    tbl[17] = '{1, 4'd0, 3'b000, 0, 0, 3'd0, 3'd0, 8'd0,  8'd6, L2, 4'b0100};
    tbl[18] = '{1, 4'd0, 3'b000, 0, 0, 3'd1, 3'd0, 8'd0,  8'd6, L2, 4'b0000};
    tbl[19] = '{1, 4'd3, 3'b100, 0, 0, 3'd1, 3'd0, 8'd0,  8'd6, L2, 4'b0000};
    tbl[20] = '{1, 4'd2, 3'b000, 0, 0, 3'd2, 3'd2, 8'd0,  8'd0, L2, 4'b0000};
    tbl[21] = '{1, 4'd0, 3'b011, 0, 0, 3'd2, 3'd2, 8'd6,  8'd0, L2, 4'b0000};
    tbl[22] = '{0, 4'd0, 3'b000, 0, 0, 3'd4, 3'd2, 8'd6,  8'd0, L2, 4'b0000};
    tbl[23] = '{0, 4'd0, 3'b000, 0, 0, 3'd0, 3'd0, 8'd0,  8'd6, L2, 4'b0100};
    tbl[24] = '{0, 4'd0, 3'b000, 0, 0, 3'd0, 3'd0, 8'd0,  8'd6, L2, 4'b0000};

    step(1, 0, 4'd0, 3'd0, 0, 0, 0);
    step(1, 0, 4'd0, 3'd0, 0, 0, 0);
    check("reset", act_vec(), {6'd0, 3'd0, 3'd0, 8'd0, 8'd0, L0, 4'b0000});

    for (int i = 0; i < 25; i++) begin
      step(0, tbl[i].pp, tbl[i].sel, tbl[i].coins, tbl[i].conf, tbl[i].canc, 0);
      check($sformatf("vec%0d", i), act_vec(),
            {6'd0, tbl[i].st, tbl[i].it, tbl[i].paid, tbl[i].chg, tbl[i].left, tbl[i].pul});
    end

    // Credit ceiling: 90 + 6 accepted, 95 + 5 rejected.
    go_pay(0);
    repeat (9) step(0, 1, 4'd0, 3'b100, 0, 0, 0);
    step(0, 1, 4'd0, 3'b011, 0, 0, 0);
    check("paid96", 64'(intf.paid), 64'd96);
    step(0, 1, 4'd0, 3'd0, 0, 1, 0);
    idle_step();
    check("refund96", {62'd0, intf.refunded, 1'b0} | 64'(intf.change) << 8, {62'd0, 2'b10} | 64'd96 << 8);
    go_pay(0);
    repeat (9) step(0, 1, 4'd0, 3'b100, 0, 0, 0);
    step(0, 1, 4'd0, 3'b010, 0, 0, 0);
    step(0, 1, 4'd0, 3'b010, 0, 0, 0);
    check("ovf_rej", {55'd0, intf.reject, intf.paid}, {55'd0, 1'b1, 8'd95});
    step(0, 1, 4'd0, 3'd0, 1, 0, 0);
    idle_step();
    check("vend95", {48'd0, intf.change, intf.left1}, {48'd0, 8'd91, 8'd8});

    // Drain item 2 and hit sold_out.
    repeat (10) begin
      go_pay(1);
      step(0, 1, 4'd0, 3'b100, 0, 0, 0);
      step(0, 1, 4'd0, 3'd0, 1, 0, 0);
      idle_step();
    end
    idle_step();
    step(0, 1, 4'd2, 3'd0, 0, 0, 0);
    check("soldout", {51'd0, intf.sold_out, intf.state, intf.left2},
          {51'd0, 1'b1, 3'd1, 8'd0});
    step(0, 1, 4'd0, 3'd0, 0, 1, 0);
    step(0, 0, 4'd0, 3'd0, 0, 0, 1);
    idle_step();
`ifdef PURCHASE_REFILL_EN
    check("refill", 64'(intf.left2), 64'd10);
`else
    check("norefill", 64'(intf.left2), 64'd0);
`endif

    // Inactivity timeout after one coin.
    go_pay(0);
    step(0, 1, 4'd0, 3'b001, 0, 0, 0);
    repeat (TimeoutCyc - 1) idle_step();
    check("to_pay", 64'(intf.state), 64'd2);
    idle_step();
    check("to_ref", 64'(intf.state), 64'd4);
    idle_step();
    check("to_done", {55'd0, intf.refunded, intf.change}, {55'd0, 1'b1, 8'd1});

    // Reset mid-session discards credit silently.
    go_pay(2);
    step(0, 1, 4'd0, 3'b010, 0, 0, 0);
    step(1, 1, 4'd0, 3'd0, 0, 0, 0);
    check("rst_pay", {52'd0, intf.state, intf.refunded, intf.paid},
          {52'd0, 3'd0, 1'b0, 8'd0});

    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] s;
      r = int'($urandom_range(0, 9));
      if (r < 4)       s = 4'(1 << r);
      else if (r == 4) s = 4'($urandom);
      else             s = 4'd0;
      step($urandom_range(0, 249) == 0, $urandom_range(0, 19) != 0, s,
           {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0},
           $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
